register_file: RTL and testbench

//   Two-read / one-write general-purpose register file for the single-cycle MIPS datapath.

---
 rtl/register_file_if.sv | 25 ++
 rtl/register_file.sv | 129 ++++++++++++
 tb/tb_register_file.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Bus interface for the two-read / one-write register file.
// The master drives addresses and write data; the slave returns both operands and Ready.
interface register_file_if #(
  parameter int Bus_Width  = 16,
  parameter int Addr_Width = 3
);
  logic [Addr_Width-1:0] rd_addr_a;
  logic [Addr_Width-1:0] rd_addr_b;
  logic [Addr_Width-1:0] wr_addr;
  logic [Bus_Width-1:0]  wr_data;
  logic                  wr_en;
  logic [Bus_Width-1:0]  data_a;
  logic [Bus_Width-1:0]  data_b;
  logic                  ready;

  modport master (
    output rd_addr_a, rd_addr_b, wr_addr, wr_data, wr_en,
    input  data_a, data_b, ready
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_addr, wr_data, wr_en,
    output data_a, data_b, ready
  );
endinterface

// File: rtl/register_file.sv
// Two-read / one-write MIPS register file with a post-reset clear sequencer (array has no reset).
// Optional macro REGFILE_WRITE_BYPASS_EN enables same-cycle write-through forwarding to both read ports.
module register_file #(
  parameter int Bus_Width  = 16,
  parameter int Addr_Width = 3
) (
  input logic            clk,
  input logic            rst,
  register_file_if.slave bus
);

  localparam int DEPTH = 2 ** Addr_Width;
  localparam logic [Addr_Width-1:0] ADDR_ZERO = {Addr_Width{1'b0}};
  localparam logic [Addr_Width-1:0] ADDR_ONE  = {{(Addr_Width-1){1'b0}}, 1'b1};
  localparam logic [Addr_Width-1:0] ADDR_LAST = {Addr_Width{1'b1}};
  localparam logic [Bus_Width-1:0]  DATA_ZERO = {Bus_Width{1'b0}};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [Addr_Width-1:0] clr_cnt_r;
  logic [Addr_Width-1:0] clr_cnt_s;
  logic                  ready_r;
  logic                  ready_s;

  logic [Bus_Width-1:0]  mem_r [DEPTH];
  logic                  mem_we_s;
  logic [Addr_Width-1:0] mem_waddr_s;
  logic [Bus_Width-1:0]  mem_wdata_s;

  logic                  run_s;
  logic                  user_wr_s;
  logic [Bus_Width-1:0]  data_a_s;
  logic [Bus_Width-1:0]  data_b_s;

  assign run_s     = (state_r == ST_RUN);
  assign user_wr_s = run_s && bus.wr_en && (bus.wr_addr != ADDR_ZERO);

  // State, clear counter and Ready are the only flops that see reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_CLEAR;
      clr_cnt_r <= ADDR_ONE;
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      clr_cnt_r <= clr_cnt_s;
      ready_r   <= ready_s;
    end
  end

  // Next-state logic and selection of the single array write port (clear vs. user write).
  always_comb begin
    state_s     = state_r;
    clr_cnt_s   = clr_cnt_r;
    ready_s     = ready_r;
    mem_we_s    = 1'b0;
    mem_waddr_s = clr_cnt_r;
    mem_wdata_s = DATA_ZERO;
    case (state_r)
      ST_CLEAR: begin
        mem_we_s = 1'b1;
        if (clr_cnt_r == ADDR_LAST) begin
          // Counter holds at the last entry instead of wrapping.
          state_s = ST_RUN;
          ready_s = 1'b1;
        end else begin
          clr_cnt_s = clr_cnt_r + ADDR_ONE;
        end
      end
      ST_RUN: begin
        if (user_wr_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = bus.wr_addr;
          mem_wdata_s = bus.wr_data;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        state_s   = ST_CLEAR;
        clr_cnt_s = ADDR_ONE;
        ready_s   = 1'b0;
      end
    endcase
  end

  // Storage array: no reset so it can map onto distributed RAM; reset blocks any write.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  function automatic logic [Bus_Width-1:0] read_port(
    input logic [Addr_Width-1:0] addr
  );
    logic [Bus_Width-1:0] val;
    if (!run_s || (addr == ADDR_ZERO)) begin
      val = DATA_ZERO;
    end else begin
`ifdef REGFILE_WRITE_BYPASS_EN
      if (user_wr_s && (bus.wr_addr == addr)) begin
        val = bus.wr_data;
      end else begin
        val = mem_r[addr];
      end
`else
      val = mem_r[addr];
`endif
    end
    return val;
  endfunction

  // Zero-latency read ports; register 0 and the whole CLEAR phase read as zero.
  always_comb begin
    data_a_s = read_port(bus.rd_addr_a);
    data_b_s = read_port(bus.rd_addr_b);
  end

  assign bus.data_a = data_a_s;
  assign bus.data_b = data_b_s;
  assign bus.ready  = ready_r;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file.
module tb_register_file;

  localparam int BW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst;
  register_file_if #(.Bus_Width(BW), .Addr_Width(AW)) bus ();

  register_file #(.Bus_Width(BW), .Addr_Width(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: register contents, readiness and edges spent clearing.
  logic [BW-1:0] ref_mem [DEPTH];
  bit            ref_ready = 1'b0;
  int            ref_clr_edges = 0;

  function automatic logic [BW-1:0] ref_read(input logic [AW-1:0] a, input logic we,
                                             input logic [AW-1:0] wa, input logic [BW-1:0] wd,
                                             input bit rdy);
    if (!rdy || a == 3'd0) return 16'h0000;
    if (BYPASS && we && wa != 3'd0 && wa == a) return wd;
    return ref_mem[a];
  endfunction

  task automatic tick();
    if (rst) begin
      ref_ready     = 1'b0;
      ref_clr_edges = 0;
    end else if (!ref_ready) begin
      ref_clr_edges++;
      if (ref_clr_edges == DEPTH - 1) begin
        ref_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
      end
    end else if (bus.wr_en && bus.wr_addr != 3'd0) begin
      ref_mem[bus.wr_addr] = bus.wr_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 0", bus.ready);
    end
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      bus.rd_addr_a = 3'($urandom_range(0, 7));
      bus.rd_addr_b = 3'($urandom_range(0, 7));
      #1;
      vectors++;
      if (bus.data_a !== 16'h0000 || bus.data_b !== 16'h0000) begin
        miscompares++;
        $display("FAIL clear_data edge %0d: got A=%h B=%h want 0/0", i, bus.data_a, bus.data_b);
      end
      vectors++;
      if (bus.ready !== 1'b0) begin
        miscompares++;
        $display("FAIL clear_ready_low before edge %0d: got %b want 0", i, bus.ready);
      end
      tick();
    end
    vectors++;
    if (bus.ready !== 1'b1 || ref_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_ready_high: got %b want 1", bus.ready);
    end
  endtask

  task automatic test_write_read();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 16'hA5A5;
    tick();
    bus.wr_addr = 3'd5; bus.wr_data = 16'h1234;
    tick();
    bus.wr_en = 1'b0; bus.rd_addr_a = 3'd3; bus.rd_addr_b = 3'd5;
    #1;
    vectors++;
    if (bus.data_a !== 16'hA5A5 || bus.data_b !== 16'h1234) begin
      miscompares++;
      $display("FAIL write_read: got A=%h B=%h want A5A5/1234", bus.data_a, bus.data_b);
    end
    bus.rd_addr_b = 3'd3;
    #1;
    vectors++;
    if (bus.data_a !== 16'hA5A5 || bus.data_b !== 16'hA5A5) begin
      miscompares++;
      $display("FAIL same_addr_read: got A=%h B=%h want A5A5/A5A5", bus.data_a, bus.data_b);
    end
  endtask

  task automatic test_r0();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 16'hFFFF;
    bus.rd_addr_a = 3'd0; bus.rd_addr_b = 3'd0;
    tick();
    bus.wr_en = 1'b0;
    #1;
    vectors++;
    if (bus.data_a !== 16'h0000 || bus.data_b !== 16'h0000) begin
      miscompares++;
      $display("FAIL r0_zero: got A=%h B=%h want 0000/0000", bus.data_a, bus.data_b);
    end
  endtask

  task automatic test_bypass();
    logic [BW-1:0] exp_pre;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 16'h0001;
    tick();
    bus.wr_data = 16'h00C3; bus.rd_addr_a = 3'd2; bus.rd_addr_b = 3'd3;
    exp_pre = BYPASS ? 16'h00C3 : 16'h0001;
    #1;
    vectors++;
    if (bus.data_a !== exp_pre) begin
      miscompares++;
      $display("FAIL bypass_pre: got %h want %h", bus.data_a, exp_pre);
    end
    vectors++;
    if (bus.data_b !== 16'hA5A5) begin
      miscompares++;
      $display("FAIL bypass_other_port: got %h want A5A5", bus.data_b);
    end
    tick();
    bus.wr_en = 1'b0;
    #1;
    vectors++;
    if (bus.data_a !== 16'h00C3) begin
      miscompares++;
      $display("FAIL bypass_post: got %h want 00C3", bus.data_a);
    end
  endtask

  task automatic test_clear_write();
    bus.wr_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd4; bus.wr_data = 16'hBEEF;
    bus.rd_addr_a = 3'd4;
    for (int i = 0; i < 7; i++) tick();
    bus.wr_en = 1'b0;
    #1;
    vectors++;
    if (bus.ready !== 1'b1 || bus.data_a !== 16'h0000) begin
      miscompares++;
      $display("FAIL clear_write: got ready=%b r4=%h want 1/0000", bus.ready, bus.data_a);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd6; bus.wr_data = 16'h5555;
    tick();
    rst = 1'b1; bus.wr_data = 16'hAAAA;
    tick();
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_ready_drop: got %b want 0", bus.ready);
    end
    rst = 1'b0; bus.wr_en = 1'b0; bus.rd_addr_a = 3'd6;
    for (int i = 1; i <= 7; i++) begin
      #1;
      vectors++;
      if (bus.ready !== 1'b0) begin
        miscompares++;
        $display("FAIL midrun_ready_low before edge %0d: got %b want 0", i, bus.ready);
      end
      tick();
    end
    vectors++;
    if (bus.ready !== 1'b1 || bus.data_a !== 16'h0000) begin
      miscompares++;
      $display("FAIL midrun_r6: got ready=%b r6=%h want 1/0000", bus.ready, bus.data_a);
    end
  endtask

  task automatic test_random();
    logic [BW-1:0] exp_a;
    logic [BW-1:0] exp_b;
    for (int n = 0; n < 400; n++) begin
      rst           = ($urandom_range(0, 63) == 0);
      bus.wr_en     = 1'($urandom_range(0, 1));
      bus.wr_addr   = 3'($urandom_range(0, 7));
      bus.wr_data   = 16'($urandom);
      bus.rd_addr_a = 3'($urandom_range(0, 7));
      bus.rd_addr_b = ($urandom_range(0, 3) == 0) ? bus.wr_addr : 3'($urandom_range(0, 7));
      #1;
      exp_a = ref_read(bus.rd_addr_a, bus.wr_en, bus.wr_addr, bus.wr_data, ref_ready);
      exp_b = ref_read(bus.rd_addr_b, bus.wr_en, bus.wr_addr, bus.wr_data, ref_ready);
      vectors++;
      if (bus.data_a !== exp_a) begin
        miscompares++;
        $display("FAIL rand_data_a cyc %0d: got %h want %h", n, bus.data_a, exp_a);
      end
      vectors++;
      if (bus.data_b !== exp_b) begin
        miscompares++;
        $display("FAIL rand_data_b cyc %0d: got %h want %h", n, bus.data_b, exp_b);
      end
      vectors++;
      if (bus.ready !== ref_ready) begin
        miscompares++;
        $display("FAIL rand_ready cyc %0d: got %b want %b", n, bus.ready, ref_ready);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = 3'd0;
    bus.wr_data   = 16'h0000;
    bus.rd_addr_a = 3'd0;
    bus.rd_addr_b = 3'd0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_clear_write();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
